dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter_pkg.sv | 27 ++
 rtl/dm_byte_merge.sv | 28 ++
 rtl/dm_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dm_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dm_arbiter_pkg
// Shared definitions for the two-requester data-memory arbiter:
//   - dm_state_t     : arbiter FSM state encoding
//   - DM_ADDR_LIMIT  : default first byte address outside the 12 KiB memory
//   - ID_M0 / ID_M1  : requester identifiers (also the round-robin pointer)
//   - be_is_partial  : true when a byte-enable mask needs read-modify-write
// ---------------------------------------------------------------------------
package dm_arbiter_pkg;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_RMW_WR = 1'b1
   } dm_state_t;

   localparam logic [31:0] DM_ADDR_LIMIT = 32'h0000_3000;

   localparam logic ID_M0 = 1'b0;
   localparam logic ID_M1 = 1'b1;

   // Masks other than all-off and all-on touch only some lanes, so the old
   // word has to be read back before it can be written.
   function automatic logic be_is_partial(input logic [3:0] be);
      return (be != 4'h0) && (be != 4'hF);
   endfunction

endpackage

// File: rtl/dm_byte_merge.sv
// ---------------------------------------------------------------------------
// dm_byte_merge
// Combinational byte-lane merge used by the read-modify-write path.
// Ports:
//   old_word  in  32  word previously read from memory
//   new_word  in  32  write data, lanes aligned to be
//   be        in   4  be[i] selects new_word bits 8i+7:8i
//   merged    out 32  new_word on enabled lanes, old_word elsewhere
// ---------------------------------------------------------------------------
module dm_byte_merge
   import dm_arbiter_pkg::*;
(
   input  logic [31:0] old_word,
   input  logic [31:0] new_word,
   input  logic [3:0]  be,
   output logic [31:0] merged
);

   always_comb begin
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = new_word[8*i +: 8];
         end
      end
   end

endmodule

// File: rtl/dm_arbiter.sv
// ---------------------------------------------------------------------------
// dm_arbiter
// Round-robin arbiter giving two requesters access to a single-port data
// memory. Reads, full-word writes and null writes finish in the grant cycle;
// partial writes take a second cycle (RMW_WR) to write the merged word back.
// Each requester gets a one-cycle RVALID with RDATA/ERR one cycle after its
// access completes. Addresses at or above ADDR_LIMIT never reach memory and
// respond with ERR=1.
// Ports:
//   clk                  in   1  clock
//   RESET_N              in   1  asynchronous active-low reset
//   M0_/M1_REQ           in   1  access request, held stable until GNT
//   M0_/M1_WE            in   1  1 = write, 0 = read
//   M0_/M1_BE            in   4  write byte enables
//   M0_/M1_A             in  32  byte address (bits 1:0 ignored)
//   M0_/M1_D             in  32  write data
//   M0_/M1_GNT           out  1  combinational accept pulse
//   M0_/M1_RVALID        out  1  response pulse
//   M0_/M1_RDATA         out 32  read data (0 for writes / errors)
//   M0_/M1_ERR           out  1  out-of-range flag
//   RAM_WE               out  1  memory word write enable
//   RAM_A                out 32  memory word-aligned byte address
//   RAM_D                out 32  memory write word
//   RAM_Q                in  32  memory combinational read word
// ---------------------------------------------------------------------------
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter logic [31:0] ADDR_LIMIT = DM_ADDR_LIMIT
)(
   input  logic        clk,
   input  logic        RESET_N,
   input  logic        M0_REQ,
   input  logic        M0_WE,
   input  logic [3:0]  M0_BE,
   input  logic [31:0] M0_A,
   input  logic [31:0] M0_D,
   output logic        M0_GNT,
   output logic        M0_RVALID,
   output logic [31:0] M0_RDATA,
   output logic        M0_ERR,
   input  logic        M1_REQ,
   input  logic        M1_WE,
   input  logic [3:0]  M1_BE,
   input  logic [31:0] M1_A,
   input  logic [31:0] M1_D,
   output logic        M1_GNT,
   output logic        M1_RVALID,
   output logic [31:0] M1_RDATA,
   output logic        M1_ERR,
   output logic        RAM_WE,
   output logic [31:0] RAM_A,
   output logic [31:0] RAM_D,
   input  logic [31:0] RAM_Q
);

   dm_state_t   state;
   logic        last;

   // Partial-write context captured in the grant cycle
   logic        rmw_id_p1;
   logic [31:0] rmw_addr_p1;
   logic [3:0]  rmw_be_p1;
   logic [31:0] rmw_d_p1;
   logic [31:0] rmw_q_p1;
   logic [31:0] rmw_word;

   // Registered responses
   logic        m0_vld_p1;
   logic [31:0] m0_rdata_p1;
   logic        m0_err_p1;
   logic        m1_vld_p1;
   logic [31:0] m1_rdata_p1;
   logic        m1_err_p1;

   // Grant-cycle selection
   logic        grant_en;
   logic        gnt0;
   logic        gnt1;
   logic        gnt_any;
   logic        gnt_id;
   logic        g_we;
   logic [3:0]  g_be;
   logic [31:0] g_addr;
   logic [31:0] g_d;
   logic        g_oor;
   logic        g_full;
   logic        g_part;
   logic [31:0] g_rdata;

   // Requests are never accepted while held in reset or during write-back.
   assign grant_en = RESET_N && (state == ST_IDLE);

   // On contention the requester that was not granted last wins.
   assign gnt0    = grant_en && M0_REQ && (!M1_REQ || (last == ID_M1));
   assign gnt1    = grant_en && M1_REQ && !gnt0;
   assign gnt_any = gnt0 || gnt1;
   assign gnt_id  = gnt1 ? ID_M1 : ID_M0;

   assign g_we   = gnt1 ? M1_WE : M0_WE;
   assign g_be   = gnt1 ? M1_BE : M0_BE;
   assign g_addr = gnt1 ? {M1_A[31:2], 2'b00} : {M0_A[31:2], 2'b00};
   assign g_d    = gnt1 ? M1_D : M0_D;

   assign g_oor   = (g_addr >= ADDR_LIMIT);
   assign g_full  = g_we && (g_be == 4'hF) && !g_oor;
   assign g_part  = g_we && be_is_partial(g_be) && !g_oor;
   assign g_rdata = (!g_we && !g_oor) ? RAM_Q : 32'h0;

   dm_byte_merge u_merge (
      .old_word (rmw_q_p1),
      .new_word (rmw_d_p1),
      .be       (rmw_be_p1),
      .merged   (rmw_word)
   );

   // Memory port: drive address/data only when an access is in flight so the
   // bus reads as zero in idle cycles.
   always_comb begin
      RAM_WE = 1'b0;
      RAM_A  = 32'h0;
      RAM_D  = 32'h0;
      if (state == ST_RMW_WR) begin
         RAM_WE = RESET_N;
         RAM_A  = rmw_addr_p1;
         RAM_D  = rmw_word;
      end else if (gnt_any) begin
         RAM_A = g_addr;
         if (g_full) begin
            RAM_WE = 1'b1;
            RAM_D  = g_d;
         end
      end
   end

   // ---- stage p0 -> p1: FSM, round-robin pointer, RMW context, responses
   always_ff @(posedge clk or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= ST_IDLE;
         last        <= ID_M1;
         rmw_id_p1   <= ID_M0;
         rmw_addr_p1 <= 32'h0;
         rmw_be_p1   <= 4'h0;
         rmw_d_p1    <= 32'h0;
         rmw_q_p1    <= 32'h0;
         m0_vld_p1   <= 1'b0;
         m0_rdata_p1 <= 32'h0;
         m0_err_p1   <= 1'b0;
         m1_vld_p1   <= 1'b0;
         m1_rdata_p1 <= 32'h0;
         m1_err_p1   <= 1'b0;
      end else begin
         m0_vld_p1 <= 1'b0;
         m1_vld_p1 <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (gnt_any) begin
                  last <= gnt_id;
                  if (g_part) begin
                     rmw_id_p1   <= gnt_id;
                     rmw_addr_p1 <= g_addr;
                     rmw_be_p1   <= g_be;
                     rmw_d_p1    <= g_d;
                     rmw_q_p1    <= RAM_Q;
                     state       <= ST_RMW_WR;
                  end else if (gnt_id == ID_M1) begin
                     m1_vld_p1   <= 1'b1;
                     m1_rdata_p1 <= g_rdata;
                     m1_err_p1   <= g_oor;
                  end else begin
                     m0_vld_p1   <= 1'b1;
                     m0_rdata_p1 <= g_rdata;
                     m0_err_p1   <= g_oor;
                  end
               end
            end
            ST_RMW_WR: begin
               state <= ST_IDLE;
               if (rmw_id_p1 == ID_M1) begin
                  m1_vld_p1   <= 1'b1;
                  m1_rdata_p1 <= 32'h0;
                  m1_err_p1   <= 1'b0;
               end else begin
                  m0_vld_p1   <= 1'b1;
                  m0_rdata_p1 <= 32'h0;
                  m0_err_p1   <= 1'b0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign M0_GNT    = gnt0;
   assign M1_GNT    = gnt1;
   assign M0_RVALID = m0_vld_p1;
   assign M0_RDATA  = m0_rdata_p1;
   assign M0_ERR    = m0_err_p1;
   assign M1_RVALID = m1_vld_p1;
   assign M1_RDATA  = m1_rdata_p1;
   assign M1_ERR    = m1_err_p1;

endmodule

// File: tb/tb_dm_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dm_arbiter
// Directed bench for dm_arbiter with a behavioural word memory attached to
// the RAM port. Inputs change 1 time unit after posedge; outputs are sampled
// on negedge.
// ---------------------------------------------------------------------------
module tb_dm_arbiter;

   logic        clk;
   logic        RESET_N;
   logic        M0_REQ, M0_WE, M1_REQ, M1_WE;
   logic [3:0]  M0_BE, M1_BE;
   logic [31:0] M0_A, M0_D, M1_A, M1_D;
   logic        M0_GNT, M0_RVALID, M0_ERR, M1_GNT, M1_RVALID, M1_ERR;
   logic [31:0] M0_RDATA, M1_RDATA;
   logic        RAM_WE;
   logic [31:0] RAM_A, RAM_D, RAM_Q;

   int compared;
   int mismatched;
   int oor_we_cnt;
   int dual_gnt_cnt;

   logic [31:0] mem [0:4095];
   logic        pre_we;
   logic [11:0] pre_idx;
   logic [31:0] pre_d;

   dm_arbiter dut (
      .clk       (clk),
      .RESET_N   (RESET_N),
      .M0_REQ    (M0_REQ),
      .M0_WE     (M0_WE),
      .M0_BE     (M0_BE),
      .M0_A      (M0_A),
      .M0_D      (M0_D),
      .M0_GNT    (M0_GNT),
      .M0_RVALID (M0_RVALID),
      .M0_RDATA  (M0_RDATA),
      .M0_ERR    (M0_ERR),
      .M1_REQ    (M1_REQ),
      .M1_WE     (M1_WE),
      .M1_BE     (M1_BE),
      .M1_A      (M1_A),
      .M1_D      (M1_D),
      .M1_GNT    (M1_GNT),
      .M1_RVALID (M1_RVALID),
      .M1_RDATA  (M1_RDATA),
      .M1_ERR    (M1_ERR),
      .RAM_WE    (RAM_WE),
      .RAM_A     (RAM_A),
      .RAM_D     (RAM_D),
      .RAM_Q     (RAM_Q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: combinational read, write on posedge.
   assign RAM_Q = mem[RAM_A[13:2]];
   always @(posedge clk) begin
      if (pre_we)
         mem[pre_idx] <= pre_d;
      else if (RAM_WE)
         mem[RAM_A[13:2]] <= RAM_D;
      if (RAM_WE && (RAM_A >= 32'h0000_3000))
         oor_we_cnt <= oor_we_cnt + 1;
   end

   always @(negedge clk) begin
      if (M0_GNT && M1_GNT)
         dual_gnt_cnt <= dual_gnt_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic m0_set(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
      M0_REQ = req; M0_WE = we; M0_BE = be; M0_A = a; M0_D = d;
   endtask

   task automatic m1_set(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
      M1_REQ = req; M1_WE = we; M1_BE = be; M1_A = a; M1_D = d;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   initial begin
      compared     = 0;
      mismatched   = 0;
      oor_we_cnt   = 0;
      dual_gnt_cnt = 0;
      RESET_N = 1'b0;
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      pre_we  = 1'b1;
      pre_idx = 12'h004;
      pre_d   = 32'h1234_5678;
      next_cycle();
      pre_we = 1'b0;

      // Reset state; a request while reset is low must not be accepted
      m0_set(1'b1, 1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("rst_m0_gnt", M0_GNT, 1'b0);
      chk("rst_ram_we", RAM_WE, 1'b0);
      chk("rst_ram_a", RAM_A, 32'h0);
      chk("rst_m0_rvalid", M0_RVALID, 1'b0);
      chk("rst_m1_rvalid", M1_RVALID, 1'b0);
      chk("rst_m0_rdata", M0_RDATA, 32'h0);
      chk("rst_m1_err", M1_ERR, 1'b0);
      next_cycle();
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      RESET_N = 1'b1;
      next_cycle();

      // Simultaneous reads of 0x10: M0 first, M1 next cycle
      m0_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      m1_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clk);
      chk("rr_m0_gnt", M0_GNT, 1'b1);
      chk("rr_m1_gnt0", M1_GNT, 1'b0);
      chk("rr_ram_a", RAM_A, 32'h10);
      next_cycle();
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rr_m1_gnt", M1_GNT, 1'b1);
      chk("rr_m0_rvalid", M0_RVALID, 1'b1);
      chk("rr_m0_rdata", M0_RDATA, 32'h1234_5678);
      chk("rr_m0_err", M0_ERR, 1'b0);
      next_cycle();
      m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("rr_m1_rvalid", M1_RVALID, 1'b1);
      chk("rr_m1_rdata", M1_RDATA, 32'h1234_5678);
      chk("rr_m0_rvalid_off", M0_RVALID, 1'b0);
      chk("idle_ram_we", RAM_WE, 1'b0);
      chk("idle_ram_a", RAM_A, 32'h0);
      chk("idle_ram_d", RAM_D, 32'h0);
      next_cycle();

      // Full write by M0, then M1 reads it back
      m0_set(1'b1, 1'b1, 4'hF, 32'h20, 32'hAABB_CCDD);
      @(negedge clk);
      chk("fw_m0_gnt", M0_GNT, 1'b1);
      chk("fw_ram_we", RAM_WE, 1'b1);
      chk("fw_ram_a", RAM_A, 32'h20);
      chk("fw_ram_d", RAM_D, 32'hAABB_CCDD);
      next_cycle();
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      m1_set(1'b1, 1'b0, 4'h0, 32'h22, 32'h0);
      @(negedge clk);
      chk("fw_m1_gnt", M1_GNT, 1'b1);
      chk("fw_m0_rvalid", M0_RVALID, 1'b1);
      chk("fw_m0_rdata", M0_RDATA, 32'h0);
      next_cycle();
      m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("fw_m1_rvalid", M1_RVALID, 1'b1);
      chk("fw_m1_rdata", M1_RDATA, 32'hAABB_CCDD);
      next_cycle();

      // Partial write by M1 (lane 1), M0 read stalled during RMW_WR
      m1_set(1'b1, 1'b1, 4'b0010, 32'h20, 32'h0000_1100);
      @(negedge clk);
      chk("pw_m1_gnt", M1_GNT, 1'b1);
      chk("pw_rd_ram_we", RAM_WE, 1'b0);
      chk("pw_rd_ram_a", RAM_A, 32'h20);
      next_cycle();
      m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      m0_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clk);
      chk("pw_m0_stall", M0_GNT, 1'b0);
      chk("pw_m1_nognt", M1_GNT, 1'b0);
      chk("pw_wr_ram_we", RAM_WE, 1'b1);
      chk("pw_wr_ram_a", RAM_A, 32'h20);
      chk("pw_wr_ram_d", RAM_D, 32'hAABB_11DD);
      chk("pw_m1_rvalid_early", M1_RVALID, 1'b0);
      next_cycle();
      @(negedge clk);
      chk("pw_m0_gnt", M0_GNT, 1'b1);
      chk("pw_m1_rvalid", M1_RVALID, 1'b1);
      chk("pw_m1_rdata", M1_RDATA, 32'h0);
      chk("pw_mem", mem[8], 32'hAABB_11DD);
      next_cycle();
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("pw_m0_rvalid", M0_RVALID, 1'b1);
      chk("pw_m0_rdata", M0_RDATA, 32'h1234_5678);
      next_cycle();

      // Out-of-range write by M0 at the limit
      m0_set(1'b1, 1'b1, 4'hF, 32'h3000, 32'h5555_5555);
      @(negedge clk);
      chk("oor_m0_gnt", M0_GNT, 1'b1);
      chk("oor_ram_we", RAM_WE, 1'b0);
      next_cycle();
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("oor_m0_rvalid", M0_RVALID, 1'b1);
      chk("oor_m0_err", M0_ERR, 1'b1);
      chk("oor_m0_rdata", M0_RDATA, 32'h0);
      chk("oor_ram_we2", RAM_WE, 1'b0);
      next_cycle();

      // Last in-range word is still writable; out-of-range read reports ERR
      m1_set(1'b1, 1'b1, 4'hF, 32'h2FFC, 32'h0BAD_F00D);
      @(negedge clk);
      chk("lim_ram_we", RAM_WE, 1'b1);
      chk("lim_ram_a", RAM_A, 32'h2FFC);
      next_cycle();
      m1_set(1'b1, 1'b0, 4'h0, 32'h4000, 32'h0);
      @(negedge clk);
      chk("lim_m1_err_wr", M1_ERR, 1'b0);
      next_cycle();
      m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("oor_rd_m1_err", M1_ERR, 1'b1);
      chk("oor_rd_m1_rdata", M1_RDATA, 32'h0);
      next_cycle();

      // Partial write by M0 abandoned by reset during RMW_WR
      m0_set(1'b1, 1'b1, 4'b0001, 32'h20, 32'h0000_00EE);
      @(negedge clk);
      chk("ab_m0_gnt", M0_GNT, 1'b1);
      next_cycle();
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      RESET_N = 1'b0;
      @(negedge clk);
      chk("ab_ram_we", RAM_WE, 1'b0);
      chk("ab_m0_rvalid", M0_RVALID, 1'b0);
      next_cycle();
      RESET_N = 1'b1;
      @(negedge clk);
      chk("ab_m0_rvalid2", M0_RVALID, 1'b0);
      chk("ab_mem", mem[8], 32'hAABB_11DD);
      next_cycle();
      m0_set(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
      m1_set(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
      @(negedge clk);
      chk("ab_m0_first", M0_GNT, 1'b1);
      chk("ab_m1_wait", M1_GNT, 1'b0);
      next_cycle();
      m0_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("ab_m0_rdata", M0_RDATA, 32'hAABB_11DD);
      chk("ab_m1_gnt", M1_GNT, 1'b1);
      next_cycle();
      m1_set(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      @(negedge clk);
      chk("ab_m1_rdata", M1_RDATA, 32'h1234_5678);
      next_cycle();

      chk("oor_we_total", oor_we_cnt, 32'd0);
      chk("dual_gnt_total", dual_gnt_cnt, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
